// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-op sequencer: opcode and FSM state
// encodings, stack word width and per-operation beat counts.
package mem_ctrl_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned CALL_BEATS = 2;
  localparam int unsigned INT_BEATS  = 3;
  localparam int unsigned RET_BEATS  = 2;
  localparam int unsigned RTI_BEATS  = 3;

  typedef enum logic [3:0] {
    OpNop   = 4'd0,
    OpLoad  = 4'd1,
    OpStore = 4'd2,
    OpPush  = 4'd3,
    OpPop   = 4'd4,
    OpCall  = 4'd5,
    OpRet   = 4'd6,
    OpInt   = 4'd7,
    OpRti   = 4'd8
  } op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPushLo  = 3'd1,
    StPushFlg = 3'd2,
    StPopB1   = 3'd3,
    StPopB2   = 3'd4,
    StCapture = 3'd5
  } state_e;

  // Number of stack words an operation will push.
  function automatic int unsigned push_beats(op_e op);
    case (op)
      OpPush:  return 1;
      OpCall:  return CALL_BEATS;
      OpInt:   return INT_BEATS;
      default: return 0;
    endcase
  endfunction

  // Number of stack words an operation will pop.
  function automatic int unsigned pop_beats(op_e op);
    case (op)
      OpPop:   return 1;
      OpRet:   return RET_BEATS;
      OpRti:   return RTI_BEATS;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/stack_depth_tracker.sv
// Stack occupancy counter, 0..STACK_DEPTH words, driven by the sequencer's
// push/pop strobes. Only instantiated when STACK_GUARD_EN is defined.
module stack_depth_tracker #(
  parameter int unsigned STACK_DEPTH = 2048,
  parameter int unsigned OCC_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [OCC_W-1:0] o_occupancy
);

  logic [OCC_W-1:0] r_occupancy;

  // Count words on the stack; saturate at both ends as a safety net.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occupancy <= '0;
    end else if (i_push && !i_pop && (32'(r_occupancy) < STACK_DEPTH)) begin
      r_occupancy <= r_occupancy + 1'b1;
    end else if (i_pop && !i_push && (r_occupancy != '0)) begin
      r_occupancy <= r_occupancy - 1'b1;
    end
  end

  assign o_occupancy = r_occupancy;

endmodule

// File: rtl/mem_op_sequencer.sv
// Memory-operation sequencer: turns single- and multi-beat ops (LOAD, STORE,
// PUSH, POP, CALL, RET, INT, RTI) into per-cycle memory-stage strobes.
// The first beat is issued combinationally in the accept cycle.
// Optional feature: define STACK_GUARD_EN to enable stack occupancy checking
// (stack_fault) via stack_depth_tracker.
module mem_op_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned FLAGS_W     = 4,
  parameter int unsigned STACK_DEPTH = 2048
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [3:0]         op,
  input  logic [15:0]        addr_in,
  input  logic [15:0]        data_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [FLAGS_W-1:0] flags_in,
  input  logic [15:0]        mem_data_in,
  output logic               memory_read,
  output logic               memory_write,
  output logic               memory_push,
  output logic               memory_pop,
  output logic [15:0]        address,
  output logic [15:0]        write_data,
  output logic               stall,
  output logic               done,
  output logic [PC_W-1:0]    pc_out,
  output logic [FLAGS_W-1:0] flags_out,
  output logic               stack_fault
);

  state_e              r_state;
  op_e                 r_op;
  logic [31:0]         r_pc;
  logic [FLAGS_W-1:0]  r_flags;
  logic [WORD_W-1:0]   r_pc_lo;
  logic [FLAGS_W-1:0]  r_flags_stage;
  logic [PC_W-1:0]     r_pc_out;
  logic [FLAGS_W-1:0]  r_flags_out;

  op_e         w_op;
  logic [31:0] w_pc_in;
  logic        w_accept;
  logic        w_fault;

  assign w_op     = op_e'(op);
  assign w_pc_in  = 32'(pc_in);
  assign w_accept = (r_state == StIdle) && op_valid;

`ifdef STACK_GUARD_EN
  localparam int unsigned OCC_W = $clog2(STACK_DEPTH + 1);

  logic [OCC_W-1:0] w_occupancy;
  logic             w_push_fits;
  logic             w_pop_fits;

  stack_depth_tracker #(
    .STACK_DEPTH(STACK_DEPTH),
    .OCC_W      (OCC_W)
  ) u_stack_depth_tracker (
    .clk        (clk),
    .reset      (reset),
    .i_push     (memory_push),
    .i_pop      (memory_pop),
    .o_occupancy(w_occupancy)
  );

  // All beats of the op must fit, checked once at accept.
  assign w_push_fits = (32'(w_occupancy) + push_beats(w_op)) <= STACK_DEPTH;
  assign w_pop_fits  = 32'(w_occupancy) >= pop_beats(w_op);
  assign w_fault     = w_accept && !(w_push_fits && w_pop_fits);
`else
  assign w_fault = 1'b0;
`endif

  // Sequencer FSM plus operand latches and staged RET/RTI captures.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_op          <= OpNop;
      r_pc          <= '0;
      r_flags       <= '0;
      r_pc_lo       <= '0;
      r_flags_stage <= '0;
      r_pc_out      <= '0;
      r_flags_out   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (op_valid) begin
            r_op    <= w_op;
            r_pc    <= w_pc_in;
            r_flags <= flags_in;
            if (!w_fault) begin
              case (w_op)
                OpCall, OpInt: r_state <= StPushLo;
                OpRet, OpRti:  r_state <= StPopB1;
                default:       r_state <= StIdle;
              endcase
            end
          end
        end
        StPushLo: r_state <= (r_op == OpInt) ? StPushFlg : StIdle;
        StPushFlg: r_state <= StIdle;
        StPopB1: begin
          // First popped word: PC low half for RET, flags for RTI.
          if (r_op == OpRet) begin
            r_pc_lo <= mem_data_in;
            r_state <= StCapture;
          end else begin
            r_flags_stage <= mem_data_in[FLAGS_W-1:0];
            r_state       <= StPopB2;
          end
        end
        StPopB2: begin
          r_pc_lo <= mem_data_in;
          r_state <= StCapture;
        end
        StCapture: begin
          // Visible outputs only change on completion.
          r_pc_out <= PC_W'({mem_data_in, r_pc_lo});
          if (r_op == OpRti) begin
            r_flags_out <= r_flags_stage;
          end
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Per-cycle strobes; reset silences everything in its own cycle.
  always_comb begin
    memory_read  = 1'b0;
    memory_write = 1'b0;
    memory_push  = 1'b0;
    memory_pop   = 1'b0;
    address      = '0;
    write_data   = '0;
    stall        = 1'b0;
    done         = 1'b0;
    if (!reset) begin
      case (r_state)
        StIdle: begin
          if (op_valid) begin
            if (w_fault) begin
              done = 1'b1;
            end else begin
              case (w_op)
                OpLoad: begin
                  memory_read = 1'b1;
                  address     = addr_in;
                  write_data  = data_in;
                  done        = 1'b1;
                end
                OpStore: begin
                  memory_write = 1'b1;
                  address      = addr_in;
                  write_data   = data_in;
                  done         = 1'b1;
                end
                OpPush: begin
                  memory_push = 1'b1;
                  write_data  = data_in;
                  done        = 1'b1;
                end
                OpPop: begin
                  memory_pop = 1'b1;
                  write_data = data_in;
                  done       = 1'b1;
                end
                OpCall, OpInt: begin
                  memory_push = 1'b1;
                  write_data  = w_pc_in[31:16];
                  stall       = 1'b1;
                end
                OpRet, OpRti: begin
                  memory_pop = 1'b1;
                  stall      = 1'b1;
                end
                default: done = 1'b1;
              endcase
            end
          end
        end
        StPushLo: begin
          memory_push = 1'b1;
          write_data  = r_pc[15:0];
          if (r_op == OpCall) begin
            done = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
        StPushFlg: begin
          memory_push = 1'b1;
          write_data  = WORD_W'(r_flags);
          done        = 1'b1;
        end
        StPopB1, StPopB2: begin
          memory_pop = 1'b1;
          stall      = 1'b1;
        end
        StCapture: done = 1'b1;
        default: ;
      endcase
    end
  end

  assign stack_fault = w_fault && !reset;
  assign pc_out      = r_pc_out;
  assign flags_out   = r_flags_out;

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Scoreboard bench for mem_op_sequencer. A reference model expands each op
// into its expected output beats; a negedge monitor compares every cycle in
// which the DUT shows a strobe, done or stack_fault. A small memory-stage
// model serves pops from the words the DUT actually pushed.
module tb_mem_op_sequencer;
  import mem_ctrl_pkg::*;

  localparam int unsigned DEPTH = 2048;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [15:0] addr_in, data_in, mem_data_in;
  logic [31:0] pc_in;
  logic [3:0]  flags_in;
  logic        memory_read, memory_write, memory_push, memory_pop;
  logic [15:0] address, write_data;
  logic        stall, done, stack_fault;
  logic [31:0] pc_out;
  logic [3:0]  flags_out;

  mem_op_sequencer #(
    .PC_W       (32),
    .FLAGS_W    (4),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op          (op),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .pc_in       (pc_in),
    .flags_in    (flags_in),
    .mem_data_in (mem_data_in),
    .memory_read (memory_read),
    .memory_write(memory_write),
    .memory_push (memory_push),
    .memory_pop  (memory_pop),
    .address     (address),
    .write_data  (write_data),
    .stall       (stall),
    .done        (done),
    .pc_out      (pc_out),
    .flags_out   (flags_out),
    .stack_fault (stack_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd, wr, ps, pp, stall, done, fault;
    logic [15:0] addr, wdata;
    logic [31:0] pc;
    logic [3:0]  flags;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_stack[$];
  logic [15:0] env_stack[$];
  logic [31:0] ref_pc;
  logic [3:0]  ref_flags;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] ref_pop();
    logic [15:0] v;
    if (ref_stack.size() == 0) return 16'h0;
    v = ref_stack.pop_back();
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  // Memory stage: record pushes, answer a pop one cycle later.
  initial begin
    logic [15:0] nxt;
    bit          had;
    mem_data_in = '0;
    forever begin
      @(negedge clk);
      had = 0;
      nxt = '0;
      if (memory_push) env_stack.push_back(write_data);
      if (memory_pop) begin
        had = 1;
        if (env_stack.size() != 0) nxt = env_stack.pop_back();
      end
      @(posedge clk);
      #1;
      mem_data_in = had ? nxt : 16'($urandom);
    end
  end

  // Monitor: every output event must match the next expected beat.
  exp_t e;
  always @(negedge clk) begin
    if (memory_read || memory_write || memory_push || memory_pop || done || stack_fault) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat rd=%b wr=%b ps=%b pp=%b dn=%b flt=%b", memory_read,
                 memory_write, memory_push, memory_pop, done, stack_fault);
      end else begin
        e = exp_q.pop_front();
        if (memory_read !== e.rd || memory_write !== e.wr || memory_push !== e.ps ||
            memory_pop !== e.pp || stall !== e.stall || done !== e.done ||
            stack_fault !== e.fault || ((e.rd || e.wr) && address !== e.addr) ||
            ((e.wr || e.ps) && write_data !== e.wdata) || pc_out !== e.pc ||
            flags_out !== e.flags) begin
          errors++;
          $display("FAIL beat got rd%b wr%b ps%b pp%b st%b dn%b fl%b a=%h wd=%h pc=%h f=%h %s",
                   memory_read, memory_write, memory_push, memory_pop, stall, done,
                   stack_fault, address, write_data, pc_out, flags_out,
                   $sformatf("expected rd%b wr%b ps%b pp%b st%b dn%b fl%b a=%h wd=%h pc=%h f=%h",
                             e.rd, e.wr, e.ps, e.pp, e.stall, e.done, e.fault, e.addr,
                             e.wdata, e.pc, e.flags));
        end
      end
    end else begin
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL quiet_stall got %b expected 0", stall);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      op_valid = 1'b0;
      op       = 4'($urandom_range(0, 15));
      addr_in  = 16'($urandom);
      data_in  = 16'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ref_stack.delete();
    env_stack.delete();
    ref_pc    = '0;
    ref_flags = '0;
  endtask

  // Expand one op into expected beats by rule, then drive it.
  task automatic issue(input op_e o, input logic [15:0] a, input logic [15:0] d,
                       input logic [31:0] pc, input logic [3:0] fl, input bit force_store,
                       input int reset_beat);
    exp_t        beats[$];
    exp_t        b, bx;
    logic [15:0] words[$];
    logic [15:0] lo, hi, fw;
    int          n_push, n_pop, n;
    bit          fault, upd_pc, upd_fl;
    logic [31:0] new_pc;
    logic [3:0]  new_fl;
    b        = '{default: 0};
    b.pc     = ref_pc;
    b.flags  = ref_flags;
    n_push   = (o == OpPush) ? 1 : (o == OpCall) ? 2 : (o == OpInt) ? 3 : 0;
    n_pop    = (o == OpPop) ? 1 : (o == OpRet) ? 2 : (o == OpRti) ? 3 : 0;
    fault    = 0;
    upd_pc   = 0;
    upd_fl   = 0;
    new_pc   = ref_pc;
    new_fl   = ref_flags;
`ifdef STACK_GUARD_EN
    fault = (ref_stack.size() + n_push > DEPTH) || (ref_stack.size() < n_pop);
`endif
    if (fault) begin
      bx = b; bx.fault = 1; bx.done = 1; beats.push_back(bx);
    end else begin
      case (o)
        OpLoad:  begin bx = b; bx.rd = 1; bx.addr = a; bx.done = 1; beats.push_back(bx); end
        OpStore: begin
          bx = b; bx.wr = 1; bx.addr = a; bx.wdata = d; bx.done = 1; beats.push_back(bx);
        end
        OpPush: begin
          bx = b; bx.ps = 1; bx.wdata = d; bx.done = 1; beats.push_back(bx);
          ref_stack.push_back(d);
        end
        OpPop: begin
          bx = b; bx.pp = 1; bx.done = 1; beats.push_back(bx);
          void'(ref_pop());
        end
        OpCall, OpInt: begin
          words.push_back(pc[31:16]);
          words.push_back(pc[15:0]);
          if (o == OpInt) words.push_back({12'h0, fl});
          for (int i = 0; i < words.size(); i++) begin
            bx = b; bx.ps = 1; bx.wdata = words[i];
            if (i == words.size() - 1) bx.done = 1; else bx.stall = 1;
            beats.push_back(bx);
            ref_stack.push_back(words[i]);
          end
        end
        OpRet, OpRti: begin
          for (int i = 0; i < n_pop; i++) begin
            bx = b; bx.pp = 1; bx.stall = 1; beats.push_back(bx);
          end
          bx = b; bx.done = 1; beats.push_back(bx);
          if (o == OpRti) begin
            fw = ref_pop(); new_fl = fw[3:0]; upd_fl = 1;
          end
          lo = ref_pop(); hi = ref_pop();
          new_pc = {hi, lo}; upd_pc = 1;
        end
        default: begin bx = b; bx.done = 1; beats.push_back(bx); end
      endcase
    end
    if (upd_pc) ref_pc = new_pc;
    if (upd_fl) ref_flags = new_fl;
    n = beats.size();
    for (int i = 0; i < n; i++) begin
      if (reset_beat < 0 || i < reset_beat) exp_q.push_back(beats[i]);
    end
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        op_valid = 1'b1; op = o; addr_in = a; data_in = d; pc_in = pc; flags_in = fl;
      end else if (force_store) begin
        op_valid = 1'b1; op = OpStore; addr_in = 16'($urandom); data_in = 16'($urandom);
      end else begin
        op_valid = 1'($urandom); op = 4'($urandom_range(0, 15));
        addr_in = 16'($urandom); data_in = 16'($urandom);
        pc_in = $urandom; flags_in = 4'($urandom);
      end
      reset = (i == reset_beat);
      @(posedge clk);
      #1;
      if (reset) break;
    end
    op_valid = 1'b0;
    if (reset) begin
      reset = 1'b0;
      ref_stack.delete();
      env_stack.delete();
      ref_pc    = '0;
      ref_flags = '0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read"},  32'(memory_read),  32'h0);
    check({tag, "_write"}, 32'(memory_write), 32'h0);
    check({tag, "_push"},  32'(memory_push),  32'h0);
    check({tag, "_pop"},   32'(memory_pop),   32'h0);
    check({tag, "_stall"}, 32'(stall),        32'h0);
    check({tag, "_done"},  32'(done),         32'h0);
    check({tag, "_fault"}, 32'(stack_fault),  32'h0);
    check({tag, "_pc"},    pc_out,            32'h0);
    check({tag, "_flags"}, 32'(flags_out),    32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = '0; addr_in = '0; data_in = '0;
    pc_in = '0; flags_in = '0; ref_pc = '0; ref_flags = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    reset = 1'b0;
    check_all_zero("after_reset");

    // CALL / RET round trip, then again with a STORE request held during RET.
    issue(OpCall, 16'h0, 16'h0, 32'h1234_5678, 4'h0, 0, -1);
    issue(OpRet, 16'h0, 16'h0, 32'h0, 4'h0, 0, -1);
    idle(1);
    check("ret_pc_out", pc_out, 32'h1234_5678);
    issue(OpCall, 16'h0, 16'h0, 32'h8765_4321, 4'h0, 0, -1);
    issue(OpRet, 16'h0, 16'h0, 32'h0, 4'h0, 1, -1);
    idle(1);
    check("ret_store_ignored_pc", pc_out, 32'h8765_4321);

    // INT then RTI restores both PC and flags.
    issue(OpInt, 16'h0, 16'h0, 32'hCAFE_BABE, 4'hA, 0, -1);
    issue(OpRti, 16'h0, 16'h0, 32'h0, 4'h0, 0, -1);
    idle(1);
    check("rti_flags_out", 32'(flags_out), 32'hA);
    check("rti_pc_out", pc_out, 32'hCAFE_BABE);

    // Reset in INT beat 1: nothing further, everything back to zero.
    issue(OpInt, 16'h0, 16'h0, 32'h0BAD_F00D, 4'h5, 0, 1);
    check_all_zero("int_reset");
    idle(2);

`ifdef STACK_GUARD_EN
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) begin
      issue(OpPush, 16'h0, 16'(i), 32'h0, 4'h0, 0, -1);
    end
    issue(OpCall, 16'h0, 16'h0, 32'h1111_2222, 4'h0, 0, -1);
    issue(OpPush, 16'h0, 16'hBEEF, 32'h0, 4'h0, 0, -1);
    issue(OpPush, 16'h0, 16'hDEAD, 32'h0, 4'h0, 0, -1);
    do_reset();
    issue(OpPop, 16'h0, 16'h0, 32'h0, 4'h0, 0, -1);
    issue(OpRet, 16'h0, 16'h0, 32'h0, 4'h0, 0, -1);
    idle(1);
`endif

    // Random op stream against the model.
    for (int k = 0; k < 400; k++) begin
      issue(op_e'($urandom_range(0, 8)), 16'($urandom), 16'($urandom), $urandom,
            4'($urandom), ($urandom_range(0, 3) == 0), -1);
      if ($urandom_range(0, 2) == 0) idle(1);
    end

    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_op_sequencer.md
MEM_OP_SEQUENCER -- requirements
Module: mem_op_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning program-counter width (fixed at two 16-bit stack words).
REQ-002 SHALL have parameter FLAGS_W, default 4, meaning CCR width pushed by INT.
REQ-003 SHALL have parameter STACK_DEPTH, default 2048, meaning stack capacity in 16-bit words.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- op_valid  in  1  op request.
- op  in  4  opcode: NOP, LOAD, STORE, PUSH, POP, CALL, RET, INT, RTI.
- addr_in  in  16  LOAD/STORE address.
- data_in  in  16  STORE/PUSH data.
- pc_in  in  PC_W  return PC for CALL/INT.
- flags_in  in  FLAGS_W  flags for INT.
- mem_data_in  in  16  memory-stage registered read data, valid one cycle after a read/pop strobe.
- memory_read, memory_write, memory_push, memory_pop  out  1 each  memory-stage strobes.
- address  out  16  memory address.
- write_data  out  16  memory write/push data.
- stall  out  1  hold upstream; more beats remain.
- done  out  1  one-cycle op-complete pulse.
- pc_out  out  PC_W  PC reassembled by RET/RTI.
- flags_out  out  FLAGS_W  flags restored by RTI.
- stack_fault  out  1  guard violation pulse.

Function
REQ-005 SHALL implement FSM states IDLE, PUSH_LO, PUSH_FLG, POP_B1, POP_B2, CAPTURE.
REQ-006 SHALL, in IDLE with op_valid, latch op, addr_in, data_in, pc_in, flags_in and issue the first beat in that same cycle.
REQ-007 SHALL make LOAD/STORE/PUSH/POP single-beat: one strobe, address=addr_in for LOAD/STORE, write_data=data_in, done same cycle, stall 0.
REQ-008 SHALL sequence CALL: t0 push pc[31:16]; t1 push pc[15:0], done.
REQ-009 SHALL sequence INT: t0 push pc[31:16]; t1 push pc[15:0]; t2 push zero-extended flags, done.
REQ-010 SHALL sequence RET: t0 pop; t1 pop, capture mem_data_in to pc_out[15:0]; t2 capture to pc_out[31:16], done.
REQ-011 SHALL sequence RTI: t0 pop; t1 pop, capture flags_out from mem_data_in[FLAGS_W-1:0]; t2 pop, capture pc_out[15:0]; t3 capture pc_out[31:16], done.
REQ-012 SHALL assert stall in every multi-beat cycle except the done cycle.
REQ-013 SHALL ignore op_valid while not IDLE.
REQ-014 SHALL assert at most one strobe per cycle; NOP or op_valid=0 in IDLE SHALL drive all strobes 0.
REQ-015 SHALL hold pc_out and flags_out between RET/RTI completions.

Reset
REQ-016 SHALL, on reset, go to IDLE and drive strobes, stall, done, stack_fault, pc_out and flags_out to 0.
REQ-017 SHALL abandon a sequence in progress on reset with no further strobes; partial pc_out captures SHALL be cleared.

Configuration
REQ-018 SHALL, with STACK_GUARD_EN defined, track stack occupancy 0..STACK_DEPTH: +1 per push, -1 per pop, reset 0.
REQ-019 SHALL, with STACK_GUARD_EN defined, check at accept that all beats fit (push: occupancy+beats<=STACK_DEPTH; pop: occupancy>=beats); on failure, issue no strobes, pulse stack_fault and done for one cycle, stay IDLE.
REQ-020 SHALL, without STACK_GUARD_EN, tie stack_fault to 0 and instantiate no occupancy logic.

Structure
REQ-021 SHALL place the opcode and FSM state enums and the word/beat-count constants in shared package mem_ctrl_pkg.
REQ-022 SHALL implement occupancy tracking as sub-module stack_depth_tracker, instantiated only under STACK_GUARD_EN.

Verification
REQ-023 SHALL cover CALL with pc_in=0x1234_5678: push 0x1234 at t0, push 0x5678 at t1, stall=1 at t0, done at t1.
REQ-024 SHALL cover RET with mem_data_in=0x5678 at t1 and 0x1234 at t2: pc_out=0x1234_5678, done at t2.
REQ-025 SHALL cover INT then RTI with flags_in=0xA: three pushes then three pops; flags_out=0xA and pc_out restored.
REQ-026 SHALL cover reset at INT t1: no push at t2, state IDLE, all outputs 0.
REQ-027 SHALL cover STACK_GUARD_EN with occupancy 2047 and CALL: no strobes, stack_fault=1, done=1; POP at occupancy 0 gives the same response.
REQ-028 SHALL cover op_valid=1 with STORE during RET t1: STORE ignored, no memory_write strobe.
